key_req_arbiter: RTL and testbench

- Multi-channel successor to the single-channel key requester. Each of N_CH channels owns a KEY_W-bit sequence counter.
- A round-robin arbiter picks one eligible channel and issues a req/key/channel transaction. The channel's counter advances only on ack.
- All outputs are registered, so there is no combinational path from ack to req or req_key.
- Sits between key-consuming agents and a shared responder in the comb_loop/verif environment.

---
 rtl/key_req_arbiter_pkg.sv | 13 +
 rtl/key_req_arbiter_if.sv | 26 ++
 rtl/key_req_arbiter_rr_pick.sv | 35 +++
 rtl/key_req_arbiter.sv | 129 ++++++++++++
 tb/tb_key_req_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_req_arbiter_pkg.sv
// Shared types and helpers for the multi-channel key request arbiter.
package key_req_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/key_req_arbiter_if.sv
// Agent/responder bundle: per-channel enables and clears in, one registered request out.
interface key_req_arbiter_if #(
    parameter int N_CH  = 4,
    parameter int KEY_W = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  clr;
    logic             ack;
    logic             req;
    logic [KEY_W-1:0] req_key;
    logic [CH_W-1:0]  req_ch;
    logic [N_CH-1:0]  done;

    modport master (
        output ch_en, clr, ack,
        input  req, req_key, req_ch, done
    );

    modport slave (
        input  ch_en, clr, ack,
        output req, req_key, req_ch, done
    );

endinterface

// File: rtl/key_req_arbiter_rr_pick.sv
// Circular priority select: first set bit of elig at or after ptr, wrapping modulo N_CH.
module rr_pick
    import key_req_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] elig,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant,
    output logic            any_valid
);

    localparam logic [CH_W:0] N_W = (CH_W + 1)'(N_CH);

    logic [CH_W:0] idx;

    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (CH_W + 1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (elig[idx[CH_W-1:0]]) begin
                grant     = idx[CH_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_req_arbiter.sv
// Round-robin arbiter issuing per-channel sequence keys; a channel's counter advances only on ack.
module key_req_arbiter
    import key_req_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int KEY_W = 4,
    parameter int WRAP  = 1,
    parameter int LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    key_req_arbiter_if.slave   bus
);

    localparam int CH_W = $clog2(N_CH);

    // Single-stage release so the FSM leaves reset cleanly aligned to clk.
    logic rst_sync_d;
    logic rst_sync_q;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [KEY_W-1:0] req_key_q, req_key_d;
    logic [CH_W-1:0]  req_ch_q, req_ch_d;
    logic [N_CH-1:0]  done_q, done_d;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic [KEY_W-1:0] cnt_q [N_CH];
    logic [KEY_W-1:0] cnt_d [N_CH];

    logic [N_CH-1:0]  elig;
    logic [CH_W-1:0]  grant;
    logic             any_valid;

    assign rst_sync_d = 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 1'b0;
        else      rst_sync_q <= rst_sync_d;
    end

    assign elig = bus.ch_en & ~done_q & ~bus.clr;

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_pick (
        .elig      (elig),
        .ptr       (rr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = REQ;
            REQ:     if (bus.ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d     = req_q;
        req_key_d = req_key_q;
        req_ch_d  = req_ch_q;
        rr_d      = rr_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_d     = 1'b1;
                    req_ch_d  = grant;
                    req_key_d = cnt_q[grant];
                end
            end
            REQ: begin
                if (bus.ack) begin
                    req_d = 1'b0;
                    rr_d  = CH_W'(next_rr(32'(req_ch_q), N_CH));
                    if (WRAP != 0) begin
                        cnt_d[req_ch_q] = cnt_q[req_ch_q] + KEY_W'(1);
                    end else if (cnt_q[req_ch_q] == KEY_W'(LIMIT)) begin
                        done_d[req_ch_q] = 1'b1;
                    end else begin
                        cnt_d[req_ch_q] = cnt_q[req_ch_q] + KEY_W'(1);
                    end
                end
            end
            default: req_d = 1'b0;
        endcase
        // Clear overrides any same-cycle ack update on that channel.
        for (int i = 0; i < N_CH; i++) begin
            if (bus.clr[i]) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            req_q     <= 1'b0;
            req_key_q <= '0;
            req_ch_q  <= '0;
            done_q    <= '0;
            rr_q      <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            req_q     <= req_d;
            req_key_q <= req_key_d;
            req_ch_q  <= req_ch_d;
            done_q    <= done_d;
            rr_q      <= rr_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.req     = req_q;
    assign bus.req_key = req_key_q;
    assign bus.req_ch  = req_ch_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_key_req_arbiter.sv
// Directed bench: a wrapping instance (dut_a) and a retiring instance with LIMIT=3 (dut_b).
module tb_key_req_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    key_req_arbiter_if #(.N_CH(4), .KEY_W(4)) bus_a ();
    key_req_arbiter_if #(.N_CH(4), .KEY_W(4)) bus_b ();

    key_req_arbiter #(.N_CH(4), .KEY_W(4), .WRAP(1), .LIMIT(15)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    key_req_arbiter #(.N_CH(4), .KEY_W(4), .WRAP(0), .LIMIT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req_a(output bit ok);
        int w = 0;
        while (bus_a.req !== 1'b1 && w < 6) begin
            tick();
            w++;
        end
        ok = (bus_a.req === 1'b1);
    endtask

    task automatic wait_req_b(output bit ok);
        int w = 0;
        while (bus_b.req !== 1'b1 && w < 6) begin
            tick();
            w++;
        end
        ok = (bus_b.req === 1'b1);
    endtask

    // Leaves the bench at a falling edge with both FSMs live.
    task automatic apply_reset();
        bus_a.ack = 1'b0; bus_a.clr = '0; bus_a.ch_en = '0;
        bus_b.ack = 1'b0; bus_b.clr = '0; bus_b.ch_en = '0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_a.ch_en = 4'b1111;
        repeat (3) begin
            tick();
            checks++;
            if ({bus_a.req, bus_a.req_key, bus_a.done} !== 9'b0) begin
                errors++;
                $display("FAIL reset_hold: req=%b key=%0d done=%b, want 0/0/0000", bus_a.req, bus_a.req_key, bus_a.done);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus_a.req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_edge1: req=%b, want 0", bus_a.req);
        end
        tick();
        checks++;
        if ({bus_a.req, bus_a.req_ch, bus_a.req_key} !== {1'b1, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_release_edge2: req=%b ch=%0d key=%0d, want 1/0/0", bus_a.req, bus_a.req_ch, bus_a.req_key);
        end
    endtask

    // Continues from test_reset with a ch0 request pending.
    task automatic test_round_robin();
        logic [1:0] exp_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_key [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        bit ok;
        for (int i = 0; i < 5; i++) begin
            wait_req_a(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_timeout[%0d]: req=%b, want 1", i, bus_a.req);
            end
            checks++;
            if ({bus_a.req_ch, bus_a.req_key} !== {exp_ch[i], exp_key[i]}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ch=%0d key=%0d, want ch=%0d key=%0d", i, bus_a.req_ch, bus_a.req_key, exp_ch[i], exp_key[i]);
            end
            bus_a.ack = 1'b1;
            tick();
            bus_a.ack = 1'b0;
            if (i == 4) bus_a.ch_en = '0;
            checks++;
            if (bus_a.req !== 1'b0) begin
                errors++;
                $display("FAIL rr_bubble[%0d]: req=%b, want 0", i, bus_a.req);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        bus_a.ch_en = 4'b0001;
        tick();
        checks++;
        if ({bus_a.req, bus_a.req_key} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL mid_pre: req=%b key=%0d, want 1/2", bus_a.req, bus_a.req_key);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus_a.req !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_drop: req=%b, want 0", bus_a.req);
        end
        tick();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bus_a.req, bus_a.req_ch, bus_a.req_key} !== {1'b1, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL mid_after_reset: req=%b ch=%0d key=%0d, want 1/0/0", bus_a.req, bus_a.req_ch, bus_a.req_key);
        end
        bus_a.ch_en = '0;
        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
    endtask

    task automatic test_hold();
        apply_reset();
        bus_a.ch_en = 4'b0100;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({bus_a.req, bus_a.req_ch, bus_a.req_key} !== {1'b1, 2'd2, 4'd0}) begin
                errors++;
                $display("FAIL hold[%0d]: req=%b ch=%0d key=%0d, want 1/2/0", c, bus_a.req, bus_a.req_ch, bus_a.req_key);
            end
            if (c == 2) bus_a.ch_en = '0;
            tick();
        end
        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
        checks++;
        if (bus_a.req !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack_drop: req=%b, want 0", bus_a.req);
        end
        bus_a.ch_en = 4'b0100;
        tick();
        checks++;
        if ({bus_a.req, bus_a.req_ch, bus_a.req_key} !== {1'b1, 2'd2, 4'd1}) begin
            errors++;
            $display("FAIL hold_next_key: req=%b ch=%0d key=%0d, want 1/2/1", bus_a.req, bus_a.req_ch, bus_a.req_key);
        end
        // Second cycle of ack lands while idle and must not advance ch2.
        bus_a.ack = 1'b1;
        bus_a.ch_en = '0;
        tick(); tick();
        bus_a.ack = 1'b0;
        bus_a.ch_en = 4'b0100;
        tick();
        checks++;
        if ({bus_a.req, bus_a.req_key} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL idle_ack_ignored: req=%b key=%0d, want 1/2", bus_a.req, bus_a.req_key);
        end
        bus_a.ch_en = '0;
        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [3:0] k;
        apply_reset();
        bus_a.ch_en = 4'b0010;
        for (int i = 0; i < 17; i++) begin
            k = 4'(i);
            wait_req_a(ok);
            checks++;
            if (!ok || {bus_a.req_ch, bus_a.req_key} !== {2'd1, k}) begin
                errors++;
                $display("FAIL wrap[%0d]: req=%b ch=%0d key=%0d, want 1/1/%0d", i, bus_a.req, bus_a.req_ch, bus_a.req_key, k);
            end
            checks++;
            if (bus_a.done !== 4'b0000) begin
                errors++;
                $display("FAIL wrap_done[%0d]: done=%b, want 0000", i, bus_a.done);
            end
            bus_a.ack = 1'b1;
            tick();
            bus_a.ack = 1'b0;
            if (i == 16) bus_a.ch_en = '0;
        end
    endtask

    task automatic test_clr_collision();
        bit ok;
        apply_reset();
        bus_a.ch_en = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            wait_req_a(ok);
            checks++;
            if (!ok || {bus_a.req_ch, bus_a.req_key} !== {2'd3, 4'(i)}) begin
                errors++;
                $display("FAIL clr_prep[%0d]: req=%b ch=%0d key=%0d, want 1/3/%0d", i, bus_a.req, bus_a.req_ch, bus_a.req_key, i);
            end
            bus_a.ack = 1'b1;
            if (i == 5) bus_a.clr = 4'b1000;
            tick();
            bus_a.ack = 1'b0;
            bus_a.clr = '0;
        end
        checks++;
        if (bus_a.req !== 1'b0) begin
            errors++;
            $display("FAIL clr_ack_drop: req=%b, want 0", bus_a.req);
        end
        wait_req_a(ok);
        checks++;
        if (!ok || {bus_a.req_ch, bus_a.req_key} !== {2'd3, 4'd0}) begin
            errors++;
            $display("FAIL clr_wins: req=%b ch=%0d key=%0d, want 1/3/0", bus_a.req, bus_a.req_ch, bus_a.req_key);
        end
        bus_a.ch_en = '0;
        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
    endtask

    task automatic test_retire();
        bit ok;
        apply_reset();
        bus_b.ch_en = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            wait_req_b(ok);
            checks++;
            if (!ok || {bus_b.req_ch, bus_b.req_key, bus_b.done} !== {2'd0, 4'(i), 4'b0000}) begin
                errors++;
                $display("FAIL retire_key[%0d]: req=%b ch=%0d key=%0d done=%b, want 1/0/%0d/0000", i, bus_b.req, bus_b.req_ch, bus_b.req_key, bus_b.done, i);
            end
            bus_b.ack = 1'b1;
            tick();
            bus_b.ack = 1'b0;
        end
        checks++;
        if (bus_b.done !== 4'b0001) begin
            errors++;
            $display("FAIL retire_done: done=%b, want 0001", bus_b.done);
        end
        repeat (4) begin
            tick();
            checks++;
            if (bus_b.req !== 1'b0) begin
                errors++;
                $display("FAIL retire_silent: req=%b key=%0d, want req 0", bus_b.req, bus_b.req_key);
            end
        end
        bus_b.clr = 4'b0001;
        tick();
        bus_b.clr = '0;
        checks++;
        if ({bus_b.req, bus_b.done} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL retire_clr: req=%b done=%b, want 0/0000", bus_b.req, bus_b.done);
        end
        tick();
        checks++;
        if ({bus_b.req, bus_b.req_ch, bus_b.req_key} !== {1'b1, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL retire_restart: req=%b ch=%0d key=%0d, want 1/0/0", bus_b.req, bus_b.req_ch, bus_b.req_key);
        end
        bus_b.ch_en = '0;
        bus_b.ack = 1'b1;
        tick();
        bus_b.ack = 1'b0;
    endtask

    initial begin
        bus_a.ack = 1'b0; bus_a.clr = '0; bus_a.ch_en = '0;
        bus_b.ack = 1'b0; bus_b.clr = '0; bus_b.ch_en = '0;
        #1;
        test_reset();
        test_round_robin();
        test_reset_mid_req();
        test_hold();
        test_wrap();
        test_clr_collision();
        test_retire();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
